// File: rtl/tx_tlp_buf_64b_pkg.sv
// Shared definitions for the 64b TX TLP store-and-forward buffer.
package tx_tlp_buf_64b_pkg;

    localparam int WORD_W       = 64;
    localparam int ENTRY_W      = 67;
    localparam int DEPTH_DEF    = 16;
    localparam int MAX_PKTS_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2
    } rd_state_e;

    // Stored word: {dwen, end, st, data}
    typedef struct packed {
        logic              dwen;
        logic              eop;
        logic              sop;
        logic [WORD_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/tx_tlp_buf_64b_fifo_mem.sv
// Dual-port FIFO storage: synchronous write, asynchronous read.
module tlp_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 67
) (
    input  logic                     clk_125,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_125) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tx_tlp_buf_64b.sv
// Store-and-forward TLP buffer between the 64b TLP generator and the 64b-to-16b bridge.
module tx_tlp_buf_64b
    import tx_tlp_buf_64b_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_PKTS = MAX_PKTS_DEF
) (
    input  logic              clk_125,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_st,
    input  logic              wr_end,
    input  logic              wr_dwen,
    output logic              wr_rdy,
    output logic              ovf_err,
    output logic [WORD_W-1:0] tx_data_64b,
    output logic              tx_st_64b,
    output logic              tx_end_64b,
    output logic              tx_dwen_64b,
    input  logic              tx_rdy_64b,
    input  logic              tx_val
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(MAX_PKTS + 1);

    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic [PW-1:0]      pkt_q, pkt_d;
    logic               wr_rdy_q, wr_rdy_d, ovf_q, ovf_d;
    rd_state_e          state_q, state_d;
    entry_t             wr_entry, head;
    logic [ENTRY_W-1:0] head_raw;
    logic               wr_acc, pop, head_sop_unused;

    assign wr_acc          = wr_en & wr_rdy_q;
    assign pop             = (state_q == S_SEND) & tx_val;
    assign wr_entry        = '{dwen: wr_dwen, eop: wr_end, sop: wr_st, data: wr_data};
    assign head            = entry_t'(head_raw);
    assign head_sop_unused = head.sop;
    assign wr_rdy          = wr_rdy_q;
    assign ovf_err         = ovf_q;

    tlp_fifo_mem #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem (
        .clk_125 (clk_125),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rptr_q),
        .rdata_o (head_raw)
    );

    // wr_rdy is computed from next-state occupancy so a pop at full still blocks that cycle's write.
    always_comb begin
        wptr_d   = wr_acc ? wptr_q + AW'(1) : wptr_q;
        rptr_d   = pop ? rptr_q + AW'(1) : rptr_q;
        occ_d    = occ_q + CW'(wr_acc) - CW'(pop);
        pkt_d    = pkt_q + PW'(wr_acc & wr_end) - PW'(pop & head.eop);
        wr_rdy_d = (occ_d < CW'(DEPTH)) && (pkt_d < PW'(MAX_PKTS));
        ovf_d    = ovf_q | (wr_en & ~wr_rdy_q);
    end

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            occ_q    <= '0;
            pkt_q    <= '0;
            wr_rdy_q <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            occ_q    <= occ_d;
            pkt_q    <= pkt_d;
            wr_rdy_q <= wr_rdy_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_st_64b   = 1'b0;
        tx_end_64b  = 1'b0;
        tx_dwen_64b = 1'b0;
        tx_data_64b = '0;
        case (state_q)
            S_IDLE: begin
                if ((pkt_q != '0) && tx_rdy_64b && tx_val) state_d = S_START;
            end
            S_START: begin
                tx_st_64b   = 1'b1;
                tx_end_64b  = head.eop;
                tx_dwen_64b = head.eop & head.dwen;
                tx_data_64b = head.data;
                state_d     = S_SEND;
            end
            S_SEND: begin
                tx_end_64b  = head.eop;
                tx_dwen_64b = head.eop & head.dwen;
                tx_data_64b = head.data;
                if (tx_val && head.eop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_tlp_buf_64b.sv
// Directed bench for tx_tlp_buf_64b: cycle table plus hand-written corner sequences.
module tb_tx_tlp_buf_64b;

    logic        clk_125 = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0, wr_st = 1'b0, wr_end = 1'b0, wr_dwen = 1'b0;
    logic [63:0] wr_data = '0;
    logic        tx_rdy_64b = 1'b0, tx_val = 1'b0;
    logic        wr_rdy, ovf_err, tx_st_64b, tx_end_64b, tx_dwen_64b;
    logic [63:0] tx_data_64b;
    logic [68:0] obs;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [63:0] D0 = 64'h4000_0002_0100_00FF;
    localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D2 = 64'hABCD_0123_0000_0000;
    localparam logic [63:0] DS = 64'h0400_0001_5A5A_5A5A;
    localparam logic [63:0] P0 = 64'h6000_0002_0000_0001;
    localparam logic [63:0] P1 = 64'h0000_00C0_FFEE_0002;
    localparam logic [63:0] DQ = 64'h7777_8888_0000_0000;

    tx_tlp_buf_64b #(.DEPTH(16), .MAX_PKTS(4)) dut (
        .clk_125     (clk_125),
        .rstn        (rstn),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_st       (wr_st),
        .wr_end      (wr_end),
        .wr_dwen     (wr_dwen),
        .wr_rdy      (wr_rdy),
        .ovf_err     (ovf_err),
        .tx_data_64b (tx_data_64b),
        .tx_st_64b   (tx_st_64b),
        .tx_end_64b  (tx_end_64b),
        .tx_dwen_64b (tx_dwen_64b),
        .tx_rdy_64b  (tx_rdy_64b),
        .tx_val      (tx_val)
    );

    always #4 clk_125 = ~clk_125;

    assign obs = {ovf_err, wr_rdy, tx_st_64b, tx_end_64b, tx_dwen_64b, tx_data_64b};

    typedef struct {
        logic        we;
        logic [63:0] d;
        logic        st, en, dw, rdy, val;
        logic        xw, xs, xe, xd;
        logic [63:0] xdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic [63:0] d, input logic st, input logic en,
                                input logic dw, input logic rdy, input logic val, input logic xw,
                                input logic xs, input logic xe, input logic xd, input logic [63:0] xdata);
        vec_t v;
        v.we = we; v.d = d; v.st = st; v.en = en; v.dw = dw; v.rdy = rdy; v.val = val;
        v.xw = xw; v.xs = xs; v.xe = xe; v.xd = xd; v.xdata = xdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [63:0] d, input logic st, input logic en,
                         input logic dw, input logic rdy, input logic val);
        wr_en = we; wr_data = d; wr_st = st; wr_end = en; wr_dwen = dw;
        tx_rdy_64b = rdy; tx_val = val;
    endtask

    task automatic tick();
        @(posedge clk_125);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 64'h0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ew [8];
        int          idx;
        bit          in_pkt;

        // 3-word MWr, bridge accepts every 4th cycle
        tbl.push_back(mk(1, D0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, D1, 0, 0, 0, 1, 0,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, D2, 0, 1, 1, 1, 0,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 1, 0, 0, D0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, D0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, D1));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, D1));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 1, 1, D2));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, D2));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        // single-word TLP; tx_val in START must not pop
        tbl.push_back(mk(1, DS, 1, 1, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 1, 1, 0, DS));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 1, 0, DS));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        // partial TLP held until its end word; then end-write coincident with end-pop
        tbl.push_back(mk(1, P0, 1, 0, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(1, P1, 0, 1, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 1, 0, 0, P0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, P0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 1, 0, P1));
        tbl.push_back(mk(1, DQ, 1, 1, 1, 1, 1,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 1, 1, 1, DQ));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 1, 1, DQ));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 1, 1,  1, 0, 0, 0, 64'h0));

        // reset state
        repeat (2) tick();
        chk("reset_state", obs, 69'h0);
        rstn = 1'b1;
        tick();
        chk("post_release", obs, {1'b0, 1'b1, 3'b000, 64'h0});

        foreach (tbl[i]) begin
            drive(tbl[i].we, tbl[i].d, tbl[i].st, tbl[i].en, tbl[i].dw, tbl[i].rdy, tbl[i].val);
            tick();
            chk($sformatf("vec%0d", i), obs,
                {1'b0, tbl[i].xw, tbl[i].xs, tbl[i].xe, tbl[i].xd, tbl[i].xdata});
        end

        // fill without end word: full after 16, 17th dropped, never forwarded
        for (int i = 0; i < 16; i++) begin
            drive(1, 64'h0D00 + 64'(i), i == 0, 0, 0, 0, 0);
            tick();
            chk($sformatf("fill_rdy%0d", i), wr_rdy, i < 15);
        end
        chk("ovf_before", ovf_err, 1'b0);
        drive(1, 64'hDEAD, 0, 0, 0, 0, 0);
        tick();
        chk("ovf_after", {ovf_err, wr_rdy}, 2'b10);
        drive(0, 64'h0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fill_no_st", {tx_st_64b, tx_data_64b}, 65'h0);
        end
        do_reset();
        chk("ovf_cleared", {ovf_err, wr_rdy}, 2'b01);

        // four 2-word TLPs: pkt limit closes wr_rdy, then in-order drain
        for (int k = 0; k < 8; k++) ew[k] = 64'hE0E0_0000_0000_0000 + 64'(k);
        for (int k = 0; k < 8; k++) begin
            drive(1, ew[k], k[0] == 1'b0, k[0] == 1'b1, 0, 0, 0);
            tick();
            chk($sformatf("pkt_rdy%0d", k), wr_rdy, k < 7);
        end
        drive(0, 64'h0, 0, 0, 0, 1, 1);
        idx = 0;
        in_pkt = 0;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            tick();
            if (tx_st_64b) begin
                chk("drain_sop", {tx_data_64b, tx_end_64b}, {ew[idx], 1'b0});
                in_pkt = 1;
            end else if (in_pkt) begin
                chk($sformatf("drain_w%0d", idx), {tx_data_64b, tx_end_64b}, {ew[idx], idx[0]});
                if (tx_end_64b) in_pkt = 0;
                idx++;
            end
        end
        chk("drain_count", idx, 8);
        repeat (2) tick();
        chk("drain_done", {wr_rdy, tx_st_64b, tx_data_64b}, {1'b1, 65'h0});

        // reset while second word is presented
        drive(1, D0, 1, 0, 0, 0, 0); tick();
        drive(1, D1, 0, 1, 0, 0, 0); tick();
        drive(0, 64'h0, 0, 0, 0, 1, 1); tick();
        chk("rst_seq_start", {tx_st_64b, tx_data_64b}, {1'b1, D0});
        tick();
        tick();
        chk("rst_seq_w1", {tx_st_64b, tx_end_64b, tx_data_64b}, {2'b01, D1});
        rstn = 1'b0;
        #1;
        chk("rst_mid_outputs", obs, 69'h0);
        repeat (2) tick();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_no_st", {tx_st_64b, tx_end_64b, tx_data_64b}, 66'h0);
        end
        chk("rst_rdy", {ovf_err, wr_rdy}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_tlp_buf_64b.md
TX_TLP_BUF_64B -- requirements
Module: tx_tlp_buf_64b

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in 64b words (power of 2, 4..64).
REQ-002 SHALL have parameter MAX_PKTS, default 4, maximum complete TLPs held.
REQ-003 SHALL have port clk_125  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write strobe from 64b TLP generator.
REQ-006 SHALL have port wr_data  input  64  TLP word, header DW0 in [63:32].
REQ-007 SHALL have port wr_st  input  1  first word of TLP.
REQ-008 SHALL have port wr_end  input  1  last word of TLP.
REQ-009 SHALL have port wr_dwen  input  1  last word carries only [63:32].
REQ-010 SHALL have port wr_rdy  output  1  space for one word and pkt count < MAX_PKTS.
REQ-011 SHALL have port ovf_err  output  1  sticky: write dropped.
REQ-012 SHALL have port tx_data_64b  output  64  word to 64b-to-16b bridge.
REQ-013 SHALL have port tx_st_64b  output  1  start-of-TLP, one cycle.
REQ-014 SHALL have port tx_end_64b  output  1  last word of TLP presented.
REQ-015 SHALL have port tx_dwen_64b  output  1  dwen of presented last word.
REQ-016 SHALL have port tx_rdy_64b  input  1  bridge ready for new TLP.
REQ-017 SHALL have port tx_val  input  1  bridge consumes current word at this edge.

Function
REQ-018 SHALL store words {dwen,end,st,data} (67 bits) in FIFO; write when wr_en=1 and wr_rdy=1.
REQ-019 SHALL drop words written while wr_rdy=0 and set ovf_err until reset.
REQ-020 SHALL be store-and-forward: pkt_cnt increments on write of word with wr_end=1; read side starts only when pkt_cnt>0.
REQ-021 SHALL run read FSM IDLE->START->SEND->IDLE.
REQ-022 IDLE: outputs tx_st/tx_end=0; go START when pkt_cnt>0, tx_rdy_64b=1, tx_val=1.
REQ-023 START: one cycle, present head word with tx_st_64b=1; go SEND; no pop.
REQ-024 SEND: present head word, tx_st_64b=0; pop head at each edge with tx_val=1.
REQ-025 SEND: tx_end_64b=1 and tx_dwen_64b=stored dwen while head word has end flag; pop of end word returns to IDLE and decrements pkt_cnt.
REQ-026 Single-word TLP (st and end both set): START with tx_st_64b=1 and tx_end_64b=1, then SEND until tx_val pop.
REQ-027 Simultaneous end-word write and end-word pop SHALL leave pkt_cnt unchanged; simultaneous write/pop at full SHALL be allowed only for pop (wr_rdy stays registered-conservative).
REQ-028 tx_data_64b SHALL be 0 in IDLE; latency wr_end write to tx_st_64b >= 2 cycles.
REQ-029 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-030 tx_val in IDLE or START SHALL cause no pop.

Reset
REQ-031 On rstn=0: FSM IDLE, pointers, occupancy, pkt_cnt=0, ovf_err=0, wr_rdy=0 then 1 after release, tx_* outputs 0.
REQ-032 Reset mid-packet SHALL discard all stored data; no partial TLP emitted after release.

Structure
REQ-033 Shared package SHALL hold word-width 64, entry width 67, FSM state encoding, default DEPTH/MAX_PKTS.
REQ-034 SHALL instantiate one sub-module tlp_fifo_mem (dual-port, sync write, async read).

Verification
REQ-035 3-word MWr (st,data,end dwen=1), bridge tx_val every 4th cycle -> tx_st_64b one cycle, 3 pops, tx_end_64b with tx_dwen_64b=1, pkt_cnt 1->0.
REQ-036 Write 16 words without wr_end -> wr_rdy=0 after 16th; 17th write dropped, ovf_err=1; no tx_st_64b.
REQ-037 Partial TLP (st only) written, tx_rdy_64b=1, tx_val=1 -> FSM stays IDLE until end word written.
REQ-038 Single-word TLP -> tx_st_64b and tx_end_64b both 1 in START cycle; one pop then IDLE.
REQ-039 Four back-to-back 2-word TLPs -> wr_rdy=0 at pkt_cnt=4; drain in order, data matches.
REQ-040 rstn low during SEND of second word -> all outputs 0, pkt_cnt=0, no further tx_st_64b.
